// File: rtl/unlock_sequencer_if.sv
// Byte-receiver and key-comparator handshake bundle for unlock_sequencer.
// master = sequencer side, slave = UART receiver / comparator side.
`timescale 1ns/1ps

interface unlock_sequencer_if #(
    parameter int KEY_BYTES = 8
);
    logic                   rx_valid;
    logic [7:0]             rx_byte;
    logic                   rx_drop;
    logic [8*KEY_BYTES-1:0] key_word;
    logic                   cmp_start;
    logic                   cmp_done;
    logic                   cmp_match;

    modport master (
        input  rx_valid, rx_byte, cmp_done, cmp_match,
        output rx_drop, key_word, cmp_start
    );

    modport slave (
        output rx_valid, rx_byte, cmp_done, cmp_match,
        input  rx_drop, key_word, cmp_start
    );
endinterface

// File: rtl/unlock_sequencer.sv
// Frames UART bytes into key attempts, launches comparisons, counts failures and drives the LEDs.
// Define UNLOCK_SEQUENCER_LOCKOUT_EN to build the timed lockout after MAX_FAILS consecutive failures.
`timescale 1ns/1ps

module unlock_sequencer #(
    parameter int KEY_BYTES      = 8,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 10000000,
    parameter int GAP_CYCLES     = 8700
) (
    input  logic                clk_10,
    input  logic                rst,
    unlock_sequencer_if.master  bus,
    output logic                led_green,
    output logic                led_red,
    output logic                locked,
    output logic [3:0]          fail_count
);

    localparam int KW = 8 * KEY_BYTES;
    localparam int BW = $clog2(KEY_BYTES + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] LAST_BYTE  = BW'(KEY_BYTES - 1);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        COMPARE,
        OPEN,
        LOCKOUT
    } state_t;

    state_t          state;
    logic [KW-1:0]   key_q;
    logic [BW-1:0]   byte_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            cmp_start_q;
    logic            rx_drop_q;
    logic [3:0]      fail_inc;
    logic [KW-1:0]   key_shifted;
    logic            result_ok;

`ifdef UNLOCK_SEQUENCER_LOCKOUT_EN
    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LW-1:0] LOCK_RELOAD = LW'(LOCKOUT_CYCLES - 1);
    logic [LW-1:0]   lock_cnt;
`else
    assign locked = 1'b0;
`endif

    assign fail_inc    = (fail_count == 4'd15) ? 4'd15 : fail_count + 4'd1;
    assign key_shifted = {key_q[KW-9:0], bus.rx_byte};
    // A result arriving while cmp_start is still high belongs to no attempt.
    assign result_ok   = bus.cmp_done && !cmp_start_q;

    assign bus.key_word  = key_q;
    assign bus.cmp_start = cmp_start_q;
    assign bus.rx_drop   = rx_drop_q;

    // NOTE: every register here is plain state (key_word included), so all are cleared
    // on reset; non-blocking assignments keep each edge reading pre-edge values.
    always_ff @(posedge clk_10) begin
        if (rst) begin
            state       <= IDLE;
            key_q       <= '0;
            byte_cnt    <= '0;
            gap_cnt     <= '0;
            cmp_start_q <= 1'b0;
            rx_drop_q   <= 1'b0;
            led_green   <= 1'b1;
            led_red     <= 1'b0;
            fail_count  <= 4'd0;
`ifdef UNLOCK_SEQUENCER_LOCKOUT_EN
            locked      <= 1'b0;
            lock_cnt    <= '0;
`endif
        end else begin
            cmp_start_q <= 1'b0;
            rx_drop_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        key_q    <= key_shifted;
                        byte_cnt <= BW'(1);
                        gap_cnt  <= GAP_RELOAD;
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (bus.rx_valid) begin
                        key_q   <= key_shifted;
                        gap_cnt <= GAP_RELOAD;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt    <= '0;
                            cmp_start_q <= 1'b1;
                            state       <= COMPARE;
                        end else begin
                            byte_cnt <= byte_cnt + BW'(1);
                        end
                    end else if (gap_cnt == '0) begin
                        // Partial attempt abandoned; it is not a failure.
                        byte_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                COMPARE: begin
                    rx_drop_q <= bus.rx_valid;
                    if (result_ok) begin
                        if (bus.cmp_match) begin
                            fail_count <= 4'd0;
                            led_red    <= 1'b1;
                            led_green  <= 1'b0;
                            state      <= OPEN;
                        end else begin
                            fail_count <= fail_inc;
`ifdef UNLOCK_SEQUENCER_LOCKOUT_EN
                            if (fail_inc == 4'(MAX_FAILS)) begin
                                lock_cnt <= LOCK_RELOAD;
                                locked   <= 1'b1;
                                state    <= LOCKOUT;
                            end else begin
                                state <= IDLE;
                            end
`else
                            state <= IDLE;
`endif
                        end
                    end
                end
                OPEN: begin
                    if (bus.rx_valid) begin
                        led_red   <= 1'b0;
                        led_green <= 1'b1;
                        key_q     <= key_shifted;
                        byte_cnt  <= BW'(1);
                        gap_cnt   <= GAP_RELOAD;
                        state     <= COLLECT;
                    end
                end
`ifdef UNLOCK_SEQUENCER_LOCKOUT_EN
                LOCKOUT: begin
                    rx_drop_q <= bus.rx_valid;
                    if (lock_cnt == '0) begin
                        locked     <= 1'b0;
                        fail_count <= 4'd0;
                        state      <= IDLE;
                    end else begin
                        lock_cnt <= lock_cnt - LW'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/unlock_sequencer.md
# unlock_sequencer

Sequencing controller between the UART byte receiver and the key comparator of the challenge board. It frames received bytes into fixed-length key attempts and launches one comparison per complete attempt. It tracks consecutive failures, enforces a timed lockout after too many failures, and owns the green/red status LEDs.

## Interface
Parameters:
- KEY_BYTES, 8: bytes per key attempt (2..16).
- MAX_FAILS, 3: consecutive failed attempts that trigger lockout (1..15).
- LOCKOUT_CYCLES, 10000000: lockout duration in clk_10 cycles (1 s).
- GAP_CYCLES, 8700: inter-byte timeout in cycles (10 byte times at 115200 baud).

Ports:
- clk_10  in  1  system clock, 10 MHz.
- rst  in  1  reset, synchronous, active-high.
- rx_valid  in  1  one-cycle strobe: rx_byte holds a received byte.
- rx_byte  in  8  received byte.
- key_word  out  8*KEY_BYTES  assembled attempt. The first received byte is in the MSB byte.
- cmp_start  out  1  one-cycle pulse: comparator must evaluate key_word.
- cmp_done  in  1  one-cycle strobe from comparator: result valid.
- cmp_match  in  1  comparison result, qualified by cmp_done.
- led_green  out  1  high while closed.
- led_red  out  1  high while open.
- locked  out  1  high during lockout.
- fail_count  out  4  consecutive failed attempts.
- rx_drop  out  1  one-cycle pulse: a byte was discarded.

## Operation
- States: IDLE, COLLECT, COMPARE, OPEN, LOCKOUT.
- Reset values: state IDLE, key_word 0, cmp_start 0, led_green 1, led_red 0, locked 0, fail_count 0, rx_drop 0, byte and gap counters 0.
- **IDLE**
  - On rx_valid: shift the byte in using key_word <= {key_word[8*KEY_BYTES-9:0], rx_byte}.
  - Set byte count to 1, load the gap timer with GAP_CYCLES-1, go to COLLECT.
- **COLLECT**
  - On rx_valid: shift the byte in, increment byte count, reload the gap timer.
  - When the count reaches KEY_BYTES: pulse cmp_start, go to COMPARE, clear byte count.
  - Gap timer at 0 with no rx_valid: discard the partial attempt (byte count 0, key_word unchanged), go to IDLE. A partial attempt does not count as a failure.
  - rx_valid in the same cycle as gap expiry: the byte wins, the timer reloads.
- **COMPARE**
  - key_word is held stable.
  - rx_valid is ignored and pulses rx_drop.
  - cmp_done with cmp_match=1: clear fail_count, go to OPEN.
  - cmp_done with cmp_match=0: increment fail_count.
    - If the new value equals MAX_FAILS (lockout compiled in): load the lockout counter, go to LOCKOUT.
    - Otherwise: go to IDLE.
- **OPEN**
  - led_red=1, led_green=0.
  - The next rx_valid closes the lock (led_red=0, led_green=1 on the next cycle) and is treated as the first byte of a new attempt (go to COLLECT).
- **LOCKOUT**
  - locked=1. Every rx_valid is dropped and pulses rx_drop.
  - Counter decrements each cycle. At 0: clear fail_count and locked, go to IDLE.
- Arithmetic:
  - fail_count saturates at 15.
  - Byte count is $clog2(KEY_BYTES+1) bits wide.
  - Lockout counter is $clog2(LOCKOUT_CYCLES) bits wide.
  - Gap counter is $clog2(GAP_CYCLES) bits wide.
- rst asserted mid-operation (including lockout or open) returns every register to its reset value on the next edge. A pending cmp_done is ignored.

## Timing
- rx_valid carrying byte KEY_BYTES at edge N: cmp_start high during cycle N+1 only; state is COMPARE from N+1.
- cmp_done at edge M: led_red, led_green, fail_count and locked reflect the result from M+1.
- cmp_done arriving in the same cycle as cmp_start is ignored. The result is accepted only from the cycle after cmp_start.
- rx_drop is asserted in the same cycle after the dropped rx_valid edge, one cycle wide per dropped byte.
- Lockout lasts exactly LOCKOUT_CYCLES cycles from LOCKOUT entry to IDLE.
- A byte accepted in IDLE or OPEN reaches key_word one cycle later.
- The gap timeout fires GAP_CYCLES cycles after the last accepted byte.

## Configuration
- Macro: UNLOCK_SEQUENCER_LOCKOUT_EN.
- Defined: LOCKOUT state, lockout counter and locked output behave as above.
- Undefined:
  - No lockout logic is built and locked is tied 0.
  - A failed attempt always returns to IDLE.
  - fail_count still counts (saturating at 15) and clears on a match.
  - LOCKOUT_CYCLES is unused.

## Test plan
- KEY_BYTES=8; send 0x11..0x88; comparator returns cmp_match=1 three cycles after cmp_start -> key_word=0x1122334455667788, one cmp_start pulse, led_red=1 and led_green=0 one cycle after cmp_done, fail_count=0.
- Send 5 bytes, then idle GAP_CYCLES cycles, then 8 bytes -> no cmp_start after the first 5; exactly one cmp_start after byte 13; key_word holds the last 8 bytes.
- Three consecutive mismatches with the macro defined, LOCKOUT_CYCLES=100 -> locked=1 after the third cmp_done; bytes sent during lockout each pulse rx_drop; locked=0 and fail_count=0 exactly 100 cycles later; the next 8 bytes produce cmp_start.
- Same stimulus with the macro undefined -> locked stays 0, fail_count=3, and the fourth attempt produces cmp_start with no wait.
- While OPEN, send one byte -> led_green=1 the next cycle, state COLLECT with count 1; 9 bytes sent during COMPARE give 9 rx_drop pulses.
- Assert rst during COMPARE and during LOCKOUT -> all outputs return to reset values; a late cmp_done causes no LED change.
